alu_issue: RTL

Operand-issue stage sitting directly upstream of the 16-bit ALU. Accepts ALU commands (op, in_a, in_b) over a valid/ready handshake into a small FIFO, presents the head command to the combinational ALU, and captures the 17-bit ALU result into a registered output with its own valid/ready handshake. Decouples the command producer from the result consumer; sustains one command per cycle.

---
 rtl/alu_issue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Operand-issue stage ahead of the 16-bit ALU: command FIFO, head presentation and a registered result slot.
// Define ALU_ISSUE_FLAGS_EN to add registered zero/carry flags next to the result.
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [15:0]            cmd_a,
    input  logic [15:0]            cmd_b,
    output logic [2:0]             alu_select,
    output logic [15:0]            alu_a,
    output logic [15:0]            alu_b,
    input  logic [16:0]            alu_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [16:0]            res_data,
    output logic [2:0]             res_op,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic                   res_zero,
    output logic                   res_carry
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2:0]  op_mem [DEPTH];
    logic [15:0] a_mem  [DEPTH];
    logic [15:0] b_mem  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          res_valid_q, res_valid_d;
    logic [16:0]   res_data_q, res_data_d;
    logic [2:0]    res_op_q, res_op_d;

    logic non_empty;
    logic push;
    logic issue;

    // Handshake decisions use registered state only, so cmd_ready never sees res_ready.
    assign non_empty = (count_q != '0);
    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign issue     = non_empty && (!res_valid_q || res_ready);

    always_comb begin
        alu_select = 3'b000;
        alu_a      = 16'h0000;
        alu_b      = 16'h0000;
        if (non_empty) begin
            alu_select = op_mem[rd_ptr_q];
            alu_a      = a_mem[rd_ptr_q];
            alu_b      = b_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_op_d    = op_mem[rd_ptr_q];
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is never reset; count and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= cmd_op;
            a_mem[wr_ptr_q]  <= cmd_a;
            b_mem[wr_ptr_q]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic res_zero_q, res_zero_d;
    logic res_carry_q, res_carry_d;

    always_comb begin
        res_zero_d  = res_zero_q;
        res_carry_d = res_carry_q;
        if (issue) begin
            res_zero_d  = (alu_result[15:0] == 16'h0000);
            res_carry_d = alu_result[16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            res_zero_q  <= res_zero_d;
            res_carry_q <= res_carry_d;
        end
    end

    assign res_zero  = res_zero_q;
    assign res_carry = res_carry_q;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign count     = count_q;

endmodule
